// File: rtl/multi_nch_disp_if.sv
// multi_nch_disp_if: CPU/switch inputs and display outputs
// of the N-channel display source selector.
interface multi_nch_disp_if #(
  parameter int CH = 8,
  parameter int DW = 32
);
  localparam int SEL_W = $clog2(CH);

  logic             EN;
  logic [SEL_W-1:0] Test;
  logic             scan;
  logic [CH*DW-1:0] Data;
  logic [CH*8-1:0]  LES;
  logic [CH*8-1:0]  point_in;
  logic [DW-1:0]    Disp_num;
  logic [7:0]       LE_out;
  logic [7:0]       point_out;
  logic [SEL_W-1:0] cur_ch;
  logic             ch_tick;

  modport master (
    output EN, Test, scan, Data, LES, point_in,
    input  Disp_num, LE_out, point_out, cur_ch, ch_tick
  );

  modport slave (
    input  EN, Test, scan, Data, LES, point_in,
    output Disp_num, LE_out, point_out, cur_ch, ch_tick
  );
endinterface

// File: rtl/multi_nch_disp.sv
// multi_nch_disp: N-channel display source selector.
// Auto-scan is built only with MULTI_AUTOSCAN_EN defined.
module multi_nch_disp #(
  parameter int          CH        = 8,
  parameter int          DW        = 32,
  parameter int          DWELL     = 50000000,
  parameter logic [31:0] INIT_DATA = 32'hAA5555AA
) (
  input logic             clk,
  input logic             rst,
  multi_nch_disp_if.slave bus
);
  localparam int SEL_W = $clog2(CH);
  localparam int CW    = $clog2(DWELL);
  localparam logic [DW-1:0] INIT_W = DW'(INIT_DATA);

  logic [DW-1:0]    c0_data_q;
  logic [7:0]       c0_blink_q;
  logic [7:0]       c0_point_q;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [DW-1:0]    mux_data;
  logic [7:0]       mux_blink;
  logic [7:0]       mux_point;
  logic [DW-1:0]    disp_q;
  logic [7:0]       le_q;
  logic [7:0]       pt_q;
  logic [SEL_W-1:0] cur_q;

  // Channel 0 captures the CPU write whenever EN is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c0_data_q  <= INIT_W;
      c0_blink_q <= 8'hFF;
      c0_point_q <= 8'h00;
    end else if (bus.EN) begin
      c0_data_q  <= bus.Data[DW-1:0];
      c0_blink_q <= bus.LES[7:0];
      c0_point_q <= bus.point_in[7:0];
    end
  end

`ifdef MULTI_AUTOSCAN_EN
  logic [CW-1:0] cnt_q, cnt_d;
  logic          scan_q;
  logic          tick_q, tick_d;

  // Manual/entry load Test; running scan steps every DWELL
  always_comb begin
    sel_d  = bus.Test;
    cnt_d  = '0;
    tick_d = 1'b0;
    if (bus.scan && scan_q) begin
      sel_d = sel_q;
      if (cnt_q == CW'(DWELL - 1)) begin
        sel_d  = sel_q + SEL_W'(1);
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Scan state; scan_q=0 after reset forces a fresh entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q  <= '0;
      cnt_q  <= '0;
      scan_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      scan_q <= bus.scan;
      tick_q <= tick_d;
    end
  end

  assign bus.ch_tick = tick_q;
`else
  // Manual only: the switch field picks the channel
  always_comb begin
    sel_d = bus.Test;
  end

  // Selected channel register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign bus.ch_tick = 1'b0;
`endif

  // Source mux: channel 0 from captured regs, rest pass through
  always_comb begin
    mux_data  = c0_data_q;
    mux_blink = c0_blink_q;
    mux_point = c0_point_q;
    for (int i = 1; i < CH; i++) begin
      if (sel_q == SEL_W'(i)) begin
        mux_data  = bus.Data[i*DW +: DW];
        mux_blink = bus.LES[i*8 +: 8];
        mux_point = bus.point_in[i*8 +: 8];
      end
    end
  end

  // Output register toward the display driver
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_q <= INIT_W;
      le_q   <= 8'hFF;
      pt_q   <= 8'h00;
      cur_q  <= '0;
    end else begin
      disp_q <= mux_data;
      le_q   <= mux_blink;
      pt_q   <= mux_point;
      cur_q  <= sel_q;
    end
  end

  assign bus.Disp_num  = disp_q;
  assign bus.LE_out    = le_q;
  assign bus.point_out = pt_q;
  assign bus.cur_ch    = cur_q;
endmodule

// File: tb/tb_multi_nch_disp.sv
// tb_multi_nch_disp: directed table, corner sequences and
// a history-based random model for multi_nch_disp.
module tb_multi_nch_disp;
  localparam int CH    = 8;
  localparam int DW    = 32;
  localparam int DWELL = 4;
  localparam logic [31:0] INIT = 32'hAA5555AA;

  typedef struct packed {
    logic          en;
    logic [2:0]    test;
    logic          scan;
    logic [255:0]  data;
    logic [63:0]   les;
    logic [63:0]   pt;
  } snap_t;

  typedef struct {
    logic [2:0]  test;
    logic [31:0] d;
    logic [7:0]  les;
    logic [7:0]  pt;
    logic [31:0] exp_d;
    logic [7:0]  exp_le;
    logic [7:0]  exp_pt;
    logic [2:0]  exp_ch;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   clk_run = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  snap_t hist[$];

  multi_nch_disp_if #(.CH(CH), .DW(DW)) bus ();

  multi_nch_disp #(
    .CH(CH), .DW(DW), .DWELL(DWELL), .INIT_DATA(INIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Channel shown after edge k (k<0: reset state)
  function automatic int sel_after(int k);
    int e;
    if (k < 0) return 0;
`ifdef MULTI_AUTOSCAN_EN
    if (!hist[k].scan) return int'(hist[k].test);
    e = k;
    while (e > 0 && hist[e-1].scan) e--;
    return (int'(hist[e].test) + (k - e) / DWELL) % CH;
`else
    e = k;
    return int'(hist[e].test);
`endif
  endfunction

  function automatic bit tick_after(int k);
    int e;
`ifdef MULTI_AUTOSCAN_EN
    if (k < 0 || !hist[k].scan) return 1'b0;
    e = k;
    while (e > 0 && hist[e-1].scan) e--;
    return (k > e) && ((k - e) % DWELL == 0);
`else
    e = k;
    return (e < -1);
`endif
  endfunction

  task automatic model_check(input int n);
    int s;
    int lc;
    logic [31:0] ed;
    logic [7:0]  el, ep;
    s = sel_after(n - 1);
    if (s == 0) begin
      ed = INIT; el = 8'hFF; ep = 8'h00;
      lc = -1;
      for (int k = 0; k <= n - 1; k++)
        if (hist[k].en) lc = k;
      if (lc >= 0) begin
        ed = hist[lc].data[31:0];
        el = hist[lc].les[7:0];
        ep = hist[lc].pt[7:0];
      end
    end else begin
      ed = hist[n].data[s*32 +: 32];
      el = hist[n].les[s*8 +: 8];
      ep = hist[n].pt[s*8 +: 8];
    end
    chk("rnd_disp", 64'(bus.Disp_num), 64'(ed));
    chk("rnd_le", 64'(bus.LE_out), 64'(el));
    chk("rnd_pt", 64'(bus.point_out), 64'(ep));
    chk("rnd_ch", 64'(bus.cur_ch), 64'(s));
    chk("rnd_tick", 64'(bus.ch_tick),
        64'(tick_after(n)));
  endtask

  initial begin
    vec_t vt[5];
    vt[0] = '{3'd5, 32'hDEADBEEF, 8'h0F, 8'h81,
              32'hDEADBEEF, 8'h0F, 8'h81, 3'd5};
    vt[1] = '{3'd3, 32'h0BADF00D, 8'h33, 8'h3C,
              32'h0BADF00D, 8'h33, 8'h3C, 3'd3};
    vt[2] = '{3'd7, 32'hCAFE0007, 8'hF0, 8'h01,
              32'hCAFE0007, 8'hF0, 8'h01, 3'd7};
    vt[3] = '{3'd1, 32'h11112222, 8'hAA, 8'h55,
              32'h11112222, 8'hAA, 8'h55, 3'd1};
    vt[4] = '{3'd0, 32'hFFFFFFFF, 8'h00, 8'hFF,
              32'h12345678, 8'hA5, 8'h5A, 3'd0};

    bus.EN = 1'b0;
    bus.Test = '0;
    bus.scan = 1'b0;
    bus.Data = '0;
    bus.LES = '0;
    bus.point_in = '0;

    // asynchronous reset with the clock stopped
    #2 rst = 1'b0;
    #1;
    chk("rst_disp", 64'(bus.Disp_num), 64'(INIT));
    chk("rst_le", 64'(bus.LE_out), 64'hFF);
    chk("rst_pt", 64'(bus.point_out), 64'h00);
    chk("rst_ch", 64'(bus.cur_ch), 64'd0);
    chk("rst_tick", 64'(bus.ch_tick), 64'd0);
    clk_run = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    // channel 0 capture
    bus.Data[31:0] = 32'h12345678;
    bus.LES[7:0] = 8'hA5;
    bus.point_in[7:0] = 8'h5A;
    bus.EN = 1'b1;
    edge1();
    chk("cap_e1", 64'(bus.Disp_num), 64'(INIT));
    bus.EN = 1'b0;
    bus.Data[31:0] = 32'h0;
    edge1();
    chk("cap_e2", 64'(bus.Disp_num), 64'h12345678);
    chk("cap_le", 64'(bus.LE_out), 64'hA5);
    chk("cap_pt", 64'(bus.point_out), 64'h5A);
    bus.Data[31:0] = 32'hFFFFFFFF;
    repeat (3) edge1();
    chk("cap_hold", 64'(bus.Disp_num), 64'h12345678);

    // manual select table
    for (int i = 0; i < 5; i++) begin
      bus.Test = vt[i].test;
      bus.Data[int'(vt[i].test)*DW +: DW] = vt[i].d;
      bus.LES[int'(vt[i].test)*8 +: 8] = vt[i].les;
      bus.point_in[int'(vt[i].test)*8 +: 8] = vt[i].pt;
      edge1();
      edge1();
      chk("tbl_disp", 64'(bus.Disp_num), 64'(vt[i].exp_d));
      chk("tbl_le", 64'(bus.LE_out), 64'(vt[i].exp_le));
      chk("tbl_pt", 64'(bus.point_out), 64'(vt[i].exp_pt));
      chk("tbl_ch", 64'(bus.cur_ch), 64'(vt[i].exp_ch));
    end

`ifdef MULTI_AUTOSCAN_EN
    // auto-scan from 6, wrapping 7 -> 0
    bus.Test = 3'd6;
    bus.scan = 1'b1;
    edge1();
    chk("as_entry_tick", 64'(bus.ch_tick), 64'd0);
    for (int j = 1; j <= 20; j++) begin
      edge1();
      chk("as_ch", 64'(bus.cur_ch),
          64'((6 + (j - 1) / DWELL) % CH));
      chk("as_tick", 64'(bus.ch_tick),
          64'(j % DWELL == 0));
    end
    repeat (2) edge1();
    // exit mid-dwell
    bus.scan = 1'b0;
    bus.Test = 3'd1;
    edge1();
    chk("exit_tick1", 64'(bus.ch_tick), 64'd0);
    edge1();
    chk("exit_tick2", 64'(bus.ch_tick), 64'd0);
    chk("exit_ch", 64'(bus.cur_ch), 64'd1);
`else
    // scan is ignored without the auto-scan build
    bus.scan = 1'b1;
    bus.Test = 3'd6;
    repeat (2) edge1();
    for (int j = 0; j < 20; j++) begin
      chk("off_ch", 64'(bus.cur_ch), 64'd6);
      chk("off_tick", 64'(bus.ch_tick), 64'd0);
      edge1();
    end
`endif

    // reset in the middle of a dwell
    bus.scan = 1'b1;
    bus.Test = 3'd4;
    repeat (6) edge1();
    #2 rst = 1'b0;
    #1;
    chk("mrst_ch", 64'(bus.cur_ch), 64'd0);
    chk("mrst_tick", 64'(bus.ch_tick), 64'd0);
    chk("mrst_disp", 64'(bus.Disp_num), 64'(INIT));
    bus.Test = 3'd3;
    @(negedge clk);
    rst = 1'b1;
    edge1();
    for (int j = 1; j <= DWELL; j++) begin
      edge1();
      chk("rs_ch", 64'(bus.cur_ch), 64'd3);
    end
    edge1();
`ifdef MULTI_AUTOSCAN_EN
    chk("rs_next", 64'(bus.cur_ch), 64'd4);
`else
    chk("rs_next", 64'(bus.cur_ch), 64'd3);
`endif

    // random run against the history model
    #2 rst = 1'b0;
    hist.delete();
    bus.scan = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 400; n++) begin
      bus.EN = ($urandom_range(3) == 0);
      bus.Test = 3'($urandom);
      if ($urandom_range(15) == 0) bus.scan = ~bus.scan;
      for (int w = 0; w < CH; w++)
        bus.Data[w*32 +: 32] = $urandom;
      bus.LES = {$urandom, $urandom};
      bus.point_in = {$urandom, $urandom};
      @(posedge clk);
      hist.push_back({bus.EN, bus.Test, bus.scan,
                      bus.Data, bus.LES, bus.point_in});
      #1;
      model_check(n);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_nch_disp.md
# multi_nch_disp

Parametrised N-channel display source selector for the seven-segment display path. It holds a CPU-written channel 0 (data word, blink mask, point mask) captured under a write enable. It selects one of CH channels either from the switch field or by timed auto-scan, and drives registered data, point and blink outputs to the display driver. It supersedes the fixed 8-channel, 32-bit, manual-only selector.

## Interface
Parameters:
- CH, 8, channel count; power of 2, 2..16
- DW, 32, data word width per channel
- DWELL, 50000000, auto-scan dwell in clk cycles per channel; ≥2
- INIT_DATA, 32'hAA5555AA, reset value of the channel 0 data register; low DW bits used

Derived constants:
- SEL_W = $clog2(CH)
- CW = $clog2(DWELL)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- EN  input  1  channel 0 capture enable (CPU write strobe)
- Test  input  SEL_W  manual channel select (switch field)
- scan  input  1  1 = auto-scan mode, 0 = manual; ignored unless MULTI_AUTOSCAN_EN
- Data  input  CH*DW  packed channel data; channel i at [i*DW +: DW]; channel 0 slice is captured, not passed through
- LES  input  CH*8  packed blink masks, channel i at [i*8 +: 8]
- point_in  input  CH*8  packed point masks, channel i at [i*8 +: 8]
- Disp_num  output  DW  selected data word, registered
- LE_out  output  8  selected blink mask, registered
- point_out  output  8  selected point mask, registered
- cur_ch  output  SEL_W  channel currently driving the outputs, registered
- ch_tick  output  1  one-cycle pulse when auto-scan advances

## Operation
- Channel 0 capture: when EN=1, the registers c0_data, c0_blink, c0_point load Data[DW-1:0], LES[7:0] and point_in[7:0]. When EN=0, they hold.
- Channels 1..CH-1 pass through combinationally to the output mux, then into the output register.
- sel register, manual mode (scan=0): sel <= Test every cycle, and the dwell counter is held at 0.
- sel register, auto-scan mode, entry: on the first cycle with scan=1 after scan=0, sel <= Test and the counter is cleared.
- sel register, auto-scan mode, running: the counter increments each cycle. When it reaches DWELL-1:
  - the counter goes to 0;
  - sel <= sel+1, wrapping from CH-1 to 0;
  - ch_tick=1 on the following cycle only.
- sel register, auto-scan exit: scan falling returns sel to Test on the next edge. No ch_tick is issued.
- Output register: Disp_num, LE_out, point_out and cur_ch are loaded every cycle from the mux indexed by sel. Channel 0 sources the c0_* registers.
- Reset (rst=0) takes effect immediately, regardless of clk:
  - c0_data = INIT_DATA, c0_blink = 8'hFF, c0_point = 8'h00
  - Disp_num = INIT_DATA, LE_out = 8'hFF, point_out = 8'h00
  - sel = 0, cur_ch = 0, counter = 0, ch_tick = 0
- Reset mid-scan abandons the dwell. After release, the block runs in the mode given by scan, and auto-scan entry loads Test as above.
- EN and a channel switch in the same cycle: both apply independently. The capture is never lost.

## Timing
- Test to outputs: 2 edges (sel, then output register).
- Channels 1..CH-1 data change to Disp_num: 1 edge.
- EN capture to Disp_num (with sel=0): 2 edges. Edge 1 loads c0_data; edge 2 loads Disp_num.
- Auto-scan: each channel is shown for exactly DWELL cycles.
  - ch_tick is high in the same cycle that sel first holds the new channel.
  - cur_ch follows one cycle later.
- No handshake; EN is a level sampled every edge, so holding EN for multiple cycles recaptures each cycle.

## Configuration
- MULTI_AUTOSCAN_EN defined:
  - the dwell counter, scan input logic and ch_tick are built, as described above.
- MULTI_AUTOSCAN_EN undefined:
  - the counter is removed and scan is ignored;
  - the block always runs manual mode (sel <= Test);
  - ch_tick is tied to 0.

## Test plan
- Reset: hold rst=0 with clk stopped → Disp_num=32'hAA5555AA, LE_out=8'hFF, point_out=8'h00, cur_ch=0, ch_tick=0, all asynchronously.
- Channel 0 capture: Test=0, Data[31:0]=32'h12345678, EN pulsed 1 cycle → Disp_num=32'h12345678 two edges later. Data[31:0] then changes with EN=0 → Disp_num is unchanged.
- Manual select: CH=8, Test=5, Data ch5=32'hDEADBEEF, LES ch5=8'h0F → after 2 edges Disp_num=32'hDEADBEEF, LE_out=8'h0F, cur_ch=5.
- Auto-scan wrap (MULTI_AUTOSCAN_EN, DWELL=4, CH=4): scan 0→1 with Test=2 → cur_ch sequence 2,3,0,1,2, each held 4 cycles. ch_tick is high once per advance, including the 3→0 wrap.
- Scan exit and reset mid-scan: drop scan mid-dwell with Test=1 → cur_ch=1 two edges later and no ch_tick. Assert rst mid-dwell → cur_ch=0 and counter=0 immediately. Release with scan=1, Test=3 → scan restarts at channel 3.
- Macro off: scan=1, DWELL=4, Test=6 → cur_ch stays 6 indefinitely and ch_tick stays 0.
